// File: rtl/music_pkg.sv
// Shared note codes, base half-period table (100 MHz clock) and FSM encoding
// for the buzzer tone generator.
package music_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_B4   = 4'd7;
  localparam logic [3:0] NOTE_C5   = 4'd8;
  localparam logic [3:0] NOTE_B5   = 4'd14;
  localparam logic [3:0] NOTE_END  = 4'd15;

  localparam int LUT_W = 18;

  localparam logic [LUT_W-1:0] HP_C = 18'd191113;
  localparam logic [LUT_W-1:0] HP_D = 18'd170262;
  localparam logic [LUT_W-1:0] HP_E = 18'd151686;
  localparam logic [LUT_W-1:0] HP_F = 18'd143173;
  localparam logic [LUT_W-1:0] HP_G = 18'd127551;
  localparam logic [LUT_W-1:0] HP_A = 18'd113636;
  localparam logic [LUT_W-1:0] HP_B = 18'd101239;

  typedef enum logic [1:0] {
    ST_SILENT = 2'd0,
    ST_PLAY   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  function automatic logic is_playable(input logic [3:0] n);
    return (n != NOTE_REST) && (n != NOTE_END);
  endfunction

  // Index 1..7 selects C..B of the lower octave; 0 is unused.
  function automatic logic [LUT_W-1:0] lut_base(input logic [2:0] idx);
    case (idx)
      3'd1:    return HP_C;
      3'd2:    return HP_D;
      3'd3:    return HP_E;
      3'd4:    return HP_F;
      3'd5:    return HP_G;
      3'd6:    return HP_A;
      3'd7:    return HP_B;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/note_period_lut.sv
// Combinational note code -> half-period (clocks) lookup. The upper octave
// reuses the lower-octave table with one extra right shift; non-playable codes give 0.
module note_period_lut
  import music_pkg::*;
#(
  parameter int HALF_W    = 18,
  parameter int DIV_SHIFT = 0
) (
  input  logic [3:0]        note_i,
  output logic [HALF_W-1:0] hp_o
);

  logic [2:0]       idx;
  logic [LUT_W-1:0] base;

  always_comb begin
    idx  = '0;
    base = '0;
    if (note_i >= NOTE_C4 && note_i <= NOTE_B4) begin
      idx  = note_i[2:0];
      base = lut_base(idx) >> DIV_SHIFT;
    end else if (note_i >= NOTE_C5 && note_i <= NOTE_B5) begin
      idx  = 3'(note_i - 4'd7);
      base = lut_base(idx) >> (DIV_SHIFT + 1);
    end
    hp_o = HALF_W'(base);
  end

endmodule

// File: rtl/buzzer_tone_gen.sv
// Square-wave buzzer driver: glitch-free pitch changes (a started high level
// always completes) and a silent articulation gap between consecutive notes.
module buzzer_tone_gen
  import music_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int HALF_W     = 18,
  parameter int DIV_SHIFT  = 0,
  parameter int GAP_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] note_to_play,
  input  logic       note_start,
  output logic       buzz_o,
  output logic       playing,
  output logic [3:0] cur_note,
  output state_e     dbg_state_o
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (GAP_CYCLES < 1 || CLK_HZ < 1) begin : g_bad_params
    $error("buzzer_tone_gen: GAP_CYCLES and CLK_HZ must be >= 1");
  end

  state_e            state_q;
  logic [3:0]        note_q;
  logic              start_q;
  logic [3:0]        cur_note_q;
  logic              buzz_q;
  logic              playing_q;
  logic [HALF_W-1:0] cnt_q;
  logic [GAP_W-1:0]  gap_q;

  logic [HALF_W-1:0] hp_new;
  logic [HALF_W-1:0] hp_cur;
  logic              can_start;
  logic              leave_play;

  // hp_new serves note loads from SILENT/GAP; hp_cur reloads while sounding.
  note_period_lut #(.HALF_W(HALF_W), .DIV_SHIFT(DIV_SHIFT)) u_lut_new (
    .note_i (note_q),
    .hp_o   (hp_new)
  );

  note_period_lut #(.HALF_W(HALF_W), .DIV_SHIFT(DIV_SHIFT)) u_lut_cur (
    .note_i (cur_note_q),
    .hp_o   (hp_cur)
  );

  assign can_start  = en && is_playable(note_q);
  assign leave_play = start_q || (note_q != cur_note_q) || !en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SILENT;
      note_q     <= '0;
      start_q    <= 1'b0;
      cur_note_q <= '0;
      buzz_q     <= 1'b0;
      playing_q  <= 1'b0;
      cnt_q      <= '0;
      gap_q      <= '0;
    end else begin
      note_q  <= note_to_play;
      start_q <= note_start;
      unique case (state_q)
        ST_SILENT: begin
          buzz_q <= 1'b0;
          if (can_start) begin
            state_q    <= ST_PLAY;
            buzz_q     <= 1'b1;
            playing_q  <= 1'b1;
            cur_note_q <= note_q;
            cnt_q      <= hp_new - HALF_W'(1);
          end
        end
        ST_PLAY: begin
          if (cnt_q == '0) begin
            buzz_q <= ~buzz_q;
            cnt_q  <= hp_cur - HALF_W'(1);
          end else begin
            cnt_q <= cnt_q - HALF_W'(1);
          end
          if (leave_play) state_q <= ST_DRAIN;
        end
        // Finish whichever half-cycle is in progress, then fall silent.
        ST_DRAIN: begin
          if (cnt_q == '0) begin
            state_q    <= ST_GAP;
            buzz_q     <= 1'b0;
            playing_q  <= 1'b0;
            cur_note_q <= '0;
            gap_q      <= GAP_W'(GAP_CYCLES - 1);
          end else begin
            cnt_q <= cnt_q - HALF_W'(1);
          end
        end
        ST_GAP: begin
          buzz_q <= 1'b0;
          if (gap_q == '0) begin
            if (can_start) begin
              state_q    <= ST_PLAY;
              buzz_q     <= 1'b1;
              playing_q  <= 1'b1;
              cur_note_q <= note_q;
              cnt_q      <= hp_new - HALF_W'(1);
            end else begin
              state_q <= ST_SILENT;
            end
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: state_q <= ST_SILENT;
      endcase
    end
  end

  assign buzz_o      = buzz_q;
  assign playing     = playing_q;
  assign cur_note    = cur_note_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed and randomized checks of buzzer_tone_gen level durations, gap
// insertion, silencing and reset behaviour with DIV_SHIFT=10, GAP_CYCLES=8.
module tb_buzzer_tone_gen;
  import music_pkg::*;

  localparam int DIV_SHIFT = 10;
  localparam int GAP       = 8;
  localparam int LIMIT     = 3000;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] note_to_play;
  logic       note_start;
  logic       buzz_o;
  logic       playing;
  logic [3:0] cur_note;
  state_e     dbg_state;

  int tests  = 0;
  int failed = 0;
  logic [31:0] exp_q[$];

  buzzer_tone_gen #(
    .CLK_HZ     (100_000_000),
    .HALF_W     (18),
    .DIV_SHIFT  (DIV_SHIFT),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .note_to_play (note_to_play),
    .note_start   (note_start),
    .buzz_o       (buzz_o),
    .playing      (playing),
    .cur_note     (cur_note),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference half-period: the published table, shifted per octave.
  function automatic int hp_of(input int n);
    int lut[7];
    lut = '{191113, 170262, 151686, 143173, 127551, 113636, 101239};
    if (n >= 1 && n <= 7)  return lut[n-1] >> DIV_SHIFT;
    if (n >= 8 && n <= 14) return lut[n-8] >> (DIV_SHIFT + 1);
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // cause: 1 note change, 2 start pulse, 3 en drop, 4 start pulse + note change
  task automatic apply_cause(input int cause, input logic [3:0] b);
    case (cause)
      1: note_to_play = b;
      2: note_start = 1'b1;
      3: en = 1'b0;
      4: begin note_to_play = b; note_start = 1'b1; end
      default: ;
    endcase
  endtask

  // Called at a negedge; counts consecutive samples at lvl, firing the event at sample k.
  task automatic run_len(input logic lvl, input int k, input int cause, input logic [3:0] b,
                         output int len);
    len = 0;
    while (buzz_o === lvl && len < LIMIT) begin
      len++;
      if (len == k) apply_cause(cause, b);
      @(negedge clk);
      note_start = 1'b0;
    end
  endtask

  task automatic meas(input string tag, input logic lvl, input int k, input int cause,
                      input logic [3:0] b);
    int len;
    logic [31:0] exp;
    run_len(lvl, k, cause, b, len);
    exp = exp_q.pop_front();
    check(tag, len, exp);
  endtask

  task automatic idle_check(input string tag, input int window, input int k, input int cause,
                            input logic [3:0] b);
    int highs = 0;
    for (int i = 1; i <= window; i++) begin
      if (buzz_o !== 1'b0) highs++;
      if (i == k) apply_cause(cause, b);
      @(negedge clk);
      note_start = 1'b0;
    end
    check({tag, "_no_tone"}, highs, 0);
    check({tag, "_playing"}, playing, 0);
    check({tag, "_cur_note"}, cur_note, 0);
  endtask

  // From SILENT: drive the note and expect the first high 2 clocks later.
  task automatic start_note(input logic [3:0] a);
    int lat = 0;
    note_to_play = a;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (buzz_o !== 1'b1 && lat < 10);
    check("start_latency", lat, 2);
    @(negedge clk);
    check("start_playing", playing, 1);
    check("start_cur_note", cur_note, a);
  endtask

  task automatic back_to_silent();
    note_to_play = 4'd0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int a, b, cause, k, hp_a, periods, in_low, lat;
    logic nxt;

    reset = 1'b1; en = 1'b0; note_to_play = 4'd0; note_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_buzz", buzz_o, 0);
    check("reset_playing", playing, 0);
    check("reset_cur_note", cur_note, 0);
    reset = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_rest_buzz", buzz_o, 0);

    // Pitch change mid-high: high completes, gap, then new pitch.
    start_note(4'd1);
    exp_q.push_back(hp_of(1));
    meas("chg_high", 1, 60, 1, 4'd5);
    check("gap_playing", playing, 0);
    check("gap_cur_note", cur_note, 0);
    exp_q.push_back(GAP);
    meas("chg_gap", 0, 0, 0, 4'd0);
    check("chg_cur_note", cur_note, 5);
    exp_q.push_back(hp_of(5)); meas("n5_high", 1, 0, 0, 4'd0);
    exp_q.push_back(hp_of(5)); meas("n5_low", 0, 0, 0, 4'd0);

    // Change seen on the very edge that ends the high: full low drains before the gap.
    exp_q.push_back(hp_of(5));
    meas("late_high", 1, hp_of(5) - 1, 1, 4'd12);
    exp_q.push_back(hp_of(5) + GAP);
    meas("late_low", 0, 0, 0, 4'd0);
    check("late_cur_note", cur_note, 12);
    exp_q.push_back(hp_of(12)); meas("n12_high", 1, 0, 0, 4'd0);

    // Start pulse and note change in the same cycle: one drain only.
    exp_q.push_back(hp_of(12) + GAP);
    meas("dual_low", 0, 20, 4, 4'd3);
    exp_q.push_back(hp_of(3)); meas("dual_high", 1, 0, 0, 4'd0);
    check("dual_cur_note", cur_note, 3);

    // Same note re-struck: gap inserted, same half-period resumes.
    exp_q.push_back(hp_of(3) + GAP);
    meas("restrike_low", 0, 30, 2, 4'd3);
    exp_q.push_back(hp_of(3)); meas("restrike_high", 1, 0, 0, 4'd0);
    exp_q.push_back(hp_of(3)); meas("restrike_low2", 0, 0, 0, 4'd0);

    // Note change during the gap is not a new boundary; latest note is taken at exit.
    exp_q.push_back(hp_of(3)); meas("pre_gapchg_high", 1, 10, 1, 4'd7);
    exp_q.push_back(GAP);      meas("gapchg_gap", 0, 3, 1, 4'd9);
    check("gapchg_cur_note", cur_note, 9);
    exp_q.push_back(hp_of(9)); meas("gapchg_high", 1, 5, 2, 4'd9);
    exp_q.push_back(GAP);      meas("gapstart_gap", 0, 4, 2, 4'd9);
    exp_q.push_back(hp_of(9)); meas("gapstart_high", 1, 0, 0, 4'd0);
    exp_q.push_back(hp_of(9)); meas("gapstart_low", 0, 0, 0, 4'd0);

    // en falls during the gap: gap completes, then silence.
    exp_q.push_back(hp_of(9)); meas("engap_high", 1, 5, 2, 4'd9);
    idle_check("engap", 40, 2, 3, 4'd0);
    back_to_silent();

    // End marker while playing: drain, gap, silence.
    start_note(4'd4);
    exp_q.push_back(hp_of(4)); meas("end_high", 1, 15, 1, 4'd15);
    idle_check("end", 40, 0, 0, 4'd0);
    back_to_silent();

    // Reset mid-high drops the output immediately; note held through release.
    start_note(4'd2);
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_buzz", buzz_o, 0);
    check("async_reset_playing", playing, 0);
    check("async_reset_cur_note", cur_note, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (buzz_o !== 1'b1 && lat < 10);
    check("post_reset_latency", lat, 2);
    @(negedge clk);
    exp_q.push_back(hp_of(2)); meas("post_reset_high", 1, 0, 0, 4'd0);
    idle_check("rest_low", hp_of(2) + GAP + 20, 3, 1, 4'd0);
    back_to_silent();

    // Randomized: note, a few whole periods, then an ending event at a random point.
    for (int t = 0; t < 12; t++) begin
      a     = $urandom_range(1, 14);
      cause = $urandom_range(1, 4);
      if (cause == 1 || cause == 4) begin
        do b = $urandom_range(0, 15); while (b == a);
      end else begin
        b = a;
      end
      nxt     = (cause != 3) && (b >= 1) && (b <= 14);
      hp_a    = hp_of(a);
      periods = $urandom_range(0, 1);
      in_low  = $urandom_range(0, 1);
      k       = $urandom_range(1, hp_a - 2);
      start_note(4'(a));
      for (int p = 0; p < periods; p++) begin
        exp_q.push_back(hp_a); meas("r_high", 1, 0, 0, 4'd0);
        exp_q.push_back(hp_a); meas("r_low", 0, 0, 0, 4'd0);
      end
      if (in_low == 0) begin
        exp_q.push_back(hp_a);
        meas("r_high_ev", 1, k, cause, 4'(b));
        check("r_gap_playing", playing, 0);
        if (nxt) begin
          exp_q.push_back(GAP); meas("r_gap", 0, 0, 0, 4'd0);
        end else begin
          idle_check("r_silent", GAP + 20, 0, 0, 4'd0);
        end
      end else begin
        exp_q.push_back(hp_a); meas("r_high_pre", 1, 0, 0, 4'd0);
        if (nxt) begin
          exp_q.push_back(hp_a + GAP);
          meas("r_low_ev", 0, k, cause, 4'(b));
        end else begin
          idle_check("r_silent_low", hp_a + GAP + 20, k, cause, 4'(b));
        end
      end
      if (nxt) begin
        check("r_next_cur_note", cur_note, b);
        exp_q.push_back(hp_of(b));
        meas("r_next_high", 1, 1, 1, 4'd0);
        idle_check("r_stop", GAP + 20, 0, 0, 4'd0);
      end
      back_to_silent();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
